banco_registradores_sb: RTL and testbench
=========================================

Name: banco_registradores_sb

Overview:
- Parametrised successor to the processor's 2-read/1-write register bank.
- Generalised in data width and register count. Optional hardwired-zero r0, optional write-to-read bypass, and a monitor port (generalised Dadoa0).
- Adds a per-register pending scoreboard for multi-cycle producers (loads, multi-cycle ALU ops), so the control unit can stall on operands that are not yet ready.
- Sits between decode and execute in the nRisc datapath.

Parameters:
- LARGURA, 8, data width in bits (>=1).
- NUM_REGS, 16, number of registers (power of 2, >=2).
- ADDR_W, $clog2(NUM_REGS), register address width (derived, not overridden).
- ZERO_R0, 0, 1 = r0 reads as 0, and writes/reservations to r0 are ignored.
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports.
- REG_MONITOR, 0, index of the register driven on Dadoa0.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous active-low reset.
- RegLido1  in  ADDR_W  read address, port 1.
- RegLido2  in  ADDR_W  read address, port 2.
- DadoLido1  out  LARGURA  read data, port 1 (combinational).
- DadoLido2  out  LARGURA  read data, port 2 (combinational).
- Pronto1  out  1  register at RegLido1 is not pending (or is being resolved this cycle, per the bypass rules).
- Pronto2  out  1  same as Pronto1, for port 2.
- EscReg  in  1  write enable.
- RegEscrito  in  ADDR_W  write address.
- DadoEscrito  in  LARGURA  write data.
- Reserva  in  1  mark RegReserva as pending (multi-cycle producer issued).
- RegReserva  in  ADDR_W  register to reserve.
- Dadoa0  out  LARGURA  stored value of register REG_MONITOR (combinational, no bypass).
- Ocupados  out  ADDR_W+1  registered count of pending registers.

Behaviour:
- Reset (Reset=0, asynchronous):
  - all registers = 0;
  - all pending bits = 0;
  - Ocupados = 0.
  - Consequently DadoLido1/2 = 0, Pronto1/2 = 1, Dadoa0 = 0 while reset is held.
  - Reset asserted mid-operation discards all pending reservations immediately.
- Write, at the rising edge:
  - if EscReg=1, reg[RegEscrito] <= DadoEscrito and pending[RegEscrito] <= 0;
  - if ZERO_R0=1 and RegEscrito=0, the write is ignored.
- Reserve, at the rising edge:
  - if Reserva=1, pending[RegReserva] <= 1;
  - if ZERO_R0=1 and RegReserva=0, the reservation is ignored.
- Simultaneous write and reserve, same register: reserve wins, so pending = 1 and the data is still written. This models the old producer retiring while a new one is issued.
- Read, combinational:
  - DadoLidoN = reg[RegLidoN], and ProntoN = !pending[RegLidoN];
  - ZERO_R0=1 and RegLidoN=0: DadoLidoN = 0, ProntoN = 1.
- Bypass, when BYPASS=1:
  - if EscReg=1, RegEscrito=RegLidoN, and the write is not ignored, then DadoLidoN = DadoEscrito and ProntoN = 1 (the resolving write is consumed in the same cycle);
  - this applies even if Reserva targets the same register in that cycle.
- When BYPASS=0, reads see only stored state. The new value is visible one cycle after the write edge.
- Both read ports may address the same register. The results are identical.
- Ocupados is updated every edge as the number of pending bits after the edge.
  - Implement it as an incremental counter: +1 when a reservation sets a previously-clear bit; −1 when a write clears a set bit (net 0 if both hit the same register and the bit was set; +0 when re-reserving an already-set bit, with no write).
  - Range 0..NUM_REGS; it cannot overflow by construction.
- A write to a non-pending register never decrements Ocupados.
- Out-of-range addresses cannot occur, since NUM_REGS = 2^ADDR_W.
- Dadoa0 reflects the stored value only. With ZERO_R0=1 and REG_MONITOR=0 it reads 0.

Decomposition:
- Shared package nrisc_pkg holds:
  - the default LARGURA and NUM_REGS constants;
  - named register indices (R0_ZERO, REG_A0).
- Natural sub-module: sb_contador_pendentes, which holds the pending bit vector plus the Ocupados up/down counter, taking the write/reserve decode as inputs.
- Data storage and read muxes stay in the top module.

Test Plan:
- Reset, then reads of r5 and r9 → DadoLido1=0, DadoLido2=0, Pronto1=Pronto2=1, Ocupados=0.
- Write r3=8'hA5 (EscReg=1) and read r3 in the same cycle:
  - BYPASS=1 → DadoLido1=8'hA5 in that cycle;
  - BYPASS=0 → old value 0 in that cycle, 8'hA5 in the next cycle.
- Reserve r4 → next cycle Pronto(r4)=0, Ocupados=1. Then write r4=8'h3C → same cycle Pronto=1 with data 8'h3C (BYPASS=1); next cycle Ocupados=0.
- Reserve r2, then in one cycle write r2=8'h11 and Reserva r2 → next cycle reg r2=8'h11, Pronto(r2)=0, Ocupados unchanged at 1.
- ZERO_R0=1: write r0=8'hFF and reserve r0 → DadoLido(r0)=0, Pronto=1, Ocupados=0. REG_MONITOR=10, write r10=8'h7E → Dadoa0=8'h7E after the edge.
- Reserve r1, r6, r7 over three cycles (Ocupados=3), then assert Reset mid-cycle → Ocupados=0 and all Pronto=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/nrisc_pkg.sv
// nrisc_pkg: shared nRisc constants for the register bank and its pending scoreboard.
package nrisc_pkg;
  localparam int LARGURA_PADRAO = 8;
  localparam int NUM_REGS_PADRAO = 16;
  localparam int R0_ZERO = 0;
  localparam int REG_A0 = 10;
endpackage

// File: rtl/banco_registradores_sb_if.sv
// banco_registradores_sb_if: decode-side read/write/reserve bus of the register bank.
interface banco_registradores_sb_if
  import nrisc_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO,
  parameter int NUM_REGS = NUM_REGS_PADRAO
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  logic [ADDR_W-1:0] RegLido1, RegLido2, RegEscrito, RegReserva;
  logic [LARGURA-1:0] DadoLido1, DadoLido2, DadoEscrito, Dadoa0;
  logic Pronto1, Pronto2, EscReg, Reserva;
  logic [ADDR_W:0] Ocupados;
  modport master (
    output RegLido1, RegLido2, EscReg, RegEscrito, DadoEscrito, Reserva, RegReserva,
    input DadoLido1, DadoLido2, Pronto1, Pronto2, Dadoa0, Ocupados
  );
  modport slave (
    input RegLido1, RegLido2, EscReg, RegEscrito, DadoEscrito, Reserva, RegReserva,
    output DadoLido1, DadoLido2, Pronto1, Pronto2, Dadoa0, Ocupados
  );
endinterface

// File: rtl/sb_contador_pendentes.sv
// sb_contador_pendentes: per-register pending bits plus an incremental count of set bits.
module sb_contador_pendentes
  import nrisc_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_PADRAO,
  localparam int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                esc,
  input  logic [ADDR_W-1:0]   reg_esc,
  input  logic                res,
  input  logic [ADDR_W-1:0]   reg_res,
  output logic [NUM_REGS-1:0] pendente,
  output logic [ADDR_W:0]     ocupados
);
  logic sobe, desce;
  assign sobe = res && !pendente[reg_res];
  // a write clearing a bit that is re-reserved in the same edge leaves it set
  assign desce = esc && pendente[reg_esc] && !(res && reg_res == reg_esc);
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      pendente <= '0;
      ocupados <= '0;
    end else begin
      if (esc) pendente[reg_esc] <= 1'b0;
      if (res) pendente[reg_res] <= 1'b1;
      ocupados <= ocupados + (ADDR_W+1)'(sobe) - (ADDR_W+1)'(desce);
    end
endmodule

// File: rtl/banco_registradores_sb.sv
// banco_registradores_sb: 2-read/1-write register bank with bypass, optional zero r0
// and a pending scoreboard so decode can stall on operands of multi-cycle producers.
module banco_registradores_sb
  import nrisc_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO,
  parameter int NUM_REGS = NUM_REGS_PADRAO,
  parameter bit ZERO_R0 = 1'b0,
  parameter bit BYPASS = 1'b1,
  parameter int REG_MONITOR = 0
) (
  input logic Clock,
  input logic Reset,
  banco_registradores_sb_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] MON = ADDR_W'(REG_MONITOR);
  logic [NUM_REGS-1:0][LARGURA-1:0] regs;
  logic [NUM_REGS-1:0] pendente;
  logic esc, res;
  logic [1:0][ADDR_W-1:0] lido;
  logic [1:0][LARGURA-1:0] dado;
  logic [1:0] pronto;
  assign esc = bus.EscReg && !(ZERO_R0 && bus.RegEscrito == '0);
  assign res = bus.Reserva && !(ZERO_R0 && bus.RegReserva == '0);
  sb_contador_pendentes #(.NUM_REGS(NUM_REGS)) u_pend (
    .Clock    (Clock),
    .Reset    (Reset),
    .esc      (esc),
    .reg_esc  (bus.RegEscrito),
    .res      (res),
    .reg_res  (bus.RegReserva),
    .pendente (pendente),
    .ocupados (bus.Ocupados)
  );
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) regs <= '0;
    else if (esc) regs[bus.RegEscrito] <= bus.DadoEscrito;
  assign lido = {bus.RegLido2, bus.RegLido1};
  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic zero, fwd;
    assign zero = ZERO_R0 && lido[p] == '0;
    // the resolving write is consumed in its own cycle, even if re-reserved
    assign fwd = BYPASS && esc && bus.RegEscrito == lido[p];
    assign dado[p] = zero ? '0 : fwd ? bus.DadoEscrito : regs[lido[p]];
    assign pronto[p] = zero || fwd || !pendente[lido[p]];
  end
  assign bus.DadoLido1 = dado[0];
  assign bus.DadoLido2 = dado[1];
  assign bus.Pronto1 = pronto[0];
  assign bus.Pronto2 = pronto[1];
  assign bus.Dadoa0 = (ZERO_R0 && MON == '0) ? '0 : regs[MON];
endmodule

// File: tb/tb_banco_registradores_sb.sv
// tb_banco_registradores_sb: three configurations driven in lockstep and checked
// against an array-based model of the bank and its pending set.
module tb_banco_registradores_sb;
  import nrisc_pkg::*;
  typedef struct packed {
    logic [7:0] d1, d2;
    logic p1, p2;
    logic [7:0] a0;
    logic [4:0] oc;
  } outs_t;
  logic Clock = 1'b0, Reset = 1'b1;
  logic [3:0] l1 = '0, l2 = '0, wa = '0, ra = '0;
  logic [7:0] wd = '0;
  logic we = 1'b0, rs = 1'b0;
  outs_t o[3];
  logic [7:0] mr[3][16];
  bit mp[3][16];
  int n_cmp = 0, n_fail = 0;
  always #5 Clock = ~Clock;
  // cfg0: bypass, monitor r0; cfg1: no bypass, monitor r5; cfg2: zero r0, bypass, monitor REG_A0
  for (genvar k = 0; k < 3; k++) begin : g
    banco_registradores_sb_if b ();
    banco_registradores_sb #(
      .ZERO_R0     (k == 2),
      .BYPASS      (k != 1),
      .REG_MONITOR (k == 2 ? REG_A0 : (k == 1 ? 5 : R0_ZERO))
    ) dut (.Clock(Clock), .Reset(Reset), .bus(b.slave));
    assign b.RegLido1 = l1;
    assign b.RegLido2 = l2;
    assign b.EscReg = we;
    assign b.RegEscrito = wa;
    assign b.DadoEscrito = wd;
    assign b.Reserva = rs;
    assign b.RegReserva = ra;
    assign o[k] = {b.DadoLido1, b.DadoLido2, b.Pronto1, b.Pronto2, b.Dadoa0, b.Ocupados};
  end
  function automatic bit zc(int c); return c == 2; endfunction
  function automatic bit bc(int c); return c != 1; endfunction
  function automatic int mc(int c); return c == 2 ? 10 : (c == 1 ? 5 : 0); endfunction
  function automatic logic [8:0] rd(int c, logic [3:0] a);
    bit weff;
    weff = we && !(zc(c) && wa == 0);
    if (zc(c) && a == 0) return {1'b1, 8'h00};
    if (bc(c) && weff && wa == a) return {1'b1, wd};
    return {!mp[c][a], mr[c][a]};
  endfunction
  function automatic outs_t expv(int c);
    outs_t e;
    logic [8:0] r1, r2;
    int cnt;
    cnt = 0;
    for (int i = 0; i < 16; i++) cnt += int'(mp[c][i]);
    r1 = rd(c, l1);
    r2 = rd(c, l2);
    e.d1 = r1[7:0]; e.p1 = r1[8];
    e.d2 = r2[7:0]; e.p2 = r2[8];
    e.a0 = mr[c][mc(c)];
    e.oc = 5'(cnt);
    return e;
  endfunction
  task automatic model_clear();
    for (int c = 0; c < 3; c++) for (int i = 0; i < 16; i++) begin mr[c][i] = '0; mp[c][i] = 0; end
  endtask
  task automatic drive(input logic [3:0] a1, a2, input logic w, input logic [3:0] w_a,
                       input logic [7:0] w_d, input logic r, input logic [3:0] r_a);
    l1 = a1; l2 = a2; we = w; wa = w_a; wd = w_d; rs = r; ra = r_a;
    #1;
  endtask
  task automatic clk_edge();
    @(posedge Clock);
    if (Reset) for (int c = 0; c < 3; c++) begin
      if (we && !(zc(c) && wa == 0)) begin mr[c][wa] = wd; mp[c][wa] = 0; end
      if (rs && !(zc(c) && ra == 0)) mp[c][ra] = 1;
    end
    @(negedge Clock);
  endtask
  task automatic do_reset();
    Reset = 1'b0;
    model_clear();
    #1 Reset = 1'b1;
  endtask
  task automatic test_reset();
    #1 Reset = 1'b0;
    model_clear();
    drive(4'd5, 4'd9, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin n_cmp++; if (o[c] !== expv(c)) begin n_fail++; $display("FAIL reset cfg%0d got=%h exp=%h", c, o[c], expv(c)); end end
    n_cmp++; if (o[0] !== outs_t'({8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 5'd0})) begin n_fail++; $display("FAIL reset_const got=%h", o[0]); end
    drive(4'd5, 4'd9, 1, 4'd5, 8'h55, 1, 4'd9);
    @(negedge Clock);
    drive(4'd5, 4'd9, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin n_cmp++; if (o[c] !== expv(c)) begin n_fail++; $display("FAIL reset_hold cfg%0d got=%h exp=%h", c, o[c], expv(c)); end end
    Reset = 1'b1;
  endtask
  task automatic test_bypass();
    do_reset();
    drive(4'd3, 4'd3, 1, 4'd3, 8'hA5, 0, 0);
    for (int c = 0; c < 3; c++) begin n_cmp++; if (o[c] !== expv(c)) begin n_fail++; $display("FAIL bypass cfg%0d got=%h exp=%h", c, o[c], expv(c)); end end
    n_cmp++; if (o[0].d1 !== 8'hA5) begin n_fail++; $display("FAIL bypass_fwd got=%h exp=a5", o[0].d1); end
    n_cmp++; if (o[1].d1 !== 8'h00) begin n_fail++; $display("FAIL nobypass_old got=%h exp=00", o[1].d1); end
    clk_edge();
    drive(4'd3, 4'd3, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin n_cmp++; if (o[c] !== expv(c)) begin n_fail++; $display("FAIL bypass_next cfg%0d got=%h exp=%h", c, o[c], expv(c)); end end
    n_cmp++; if (o[1].d1 !== 8'hA5) begin n_fail++; $display("FAIL nobypass_new got=%h exp=a5", o[1].d1); end
  endtask
  task automatic test_reserve();
    do_reset();
    drive(4'd4, 4'd0, 0, 0, 0, 1, 4'd4);
    clk_edge();
    drive(4'd4, 4'd4, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin n_cmp++; if (o[c] !== expv(c)) begin n_fail++; $display("FAIL reserve cfg%0d got=%h exp=%h", c, o[c], expv(c)); end end
    n_cmp++; if ({o[0].p1, o[0].oc} !== {1'b0, 5'd1}) begin n_fail++; $display("FAIL reserve_pend got=%b/%0d exp=0/1", o[0].p1, o[0].oc); end
    drive(4'd4, 4'd4, 1, 4'd4, 8'h3C, 0, 0);
    for (int c = 0; c < 3; c++) begin n_cmp++; if (o[c] !== expv(c)) begin n_fail++; $display("FAIL resolve cfg%0d got=%h exp=%h", c, o[c], expv(c)); end end
    n_cmp++; if ({o[0].p1, o[0].d1} !== {1'b1, 8'h3C}) begin n_fail++; $display("FAIL resolve_fwd got=%b/%h exp=1/3c", o[0].p1, o[0].d1); end
    clk_edge();
    drive(4'd4, 4'd4, 0, 0, 0, 0, 0);
    n_cmp++; if (o[0].oc !== 5'd0) begin n_fail++; $display("FAIL resolve_count got=%0d exp=0", o[0].oc); end
  endtask
  task automatic test_same_cycle();
    do_reset();
    drive(4'd2, 4'd0, 0, 0, 0, 1, 4'd2);
    clk_edge();
    drive(4'd2, 4'd2, 1, 4'd2, 8'h11, 1, 4'd2);
    for (int c = 0; c < 3; c++) begin n_cmp++; if (o[c] !== expv(c)) begin n_fail++; $display("FAIL wr_res cfg%0d got=%h exp=%h", c, o[c], expv(c)); end end
    clk_edge();
    drive(4'd2, 4'd2, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin n_cmp++; if (o[c] !== expv(c)) begin n_fail++; $display("FAIL wr_res_next cfg%0d got=%h exp=%h", c, o[c], expv(c)); end end
    n_cmp++; if ({o[1].d1, o[1].p1, o[1].oc} !== {8'h11, 1'b0, 5'd1}) begin n_fail++; $display("FAIL wr_res_wins got=%h/%b/%0d exp=11/0/1", o[1].d1, o[1].p1, o[1].oc); end
  endtask
  task automatic test_zero_r0();
    do_reset();
    drive(4'd0, 4'd0, 1, 4'd0, 8'hFF, 1, 4'd0);
    for (int c = 0; c < 3; c++) begin n_cmp++; if (o[c] !== expv(c)) begin n_fail++; $display("FAIL r0_write cfg%0d got=%h exp=%h", c, o[c], expv(c)); end end
    clk_edge();
    drive(4'd0, 4'd0, 1, 4'd10, 8'h7E, 0, 0);
    for (int c = 0; c < 3; c++) begin n_cmp++; if (o[c] !== expv(c)) begin n_fail++; $display("FAIL r0_read cfg%0d got=%h exp=%h", c, o[c], expv(c)); end end
    n_cmp++; if ({o[2].d1, o[2].p1, o[2].oc} !== {8'h00, 1'b1, 5'd0}) begin n_fail++; $display("FAIL r0_zero got=%h/%b/%0d exp=00/1/0", o[2].d1, o[2].p1, o[2].oc); end
    clk_edge();
    drive(4'd10, 4'd0, 0, 0, 0, 0, 0);
    n_cmp++; if (o[2].a0 !== 8'h7E) begin n_fail++; $display("FAIL monitor got=%h exp=7e", o[2].a0); end
    for (int c = 0; c < 3; c++) begin n_cmp++; if (o[c] !== expv(c)) begin n_fail++; $display("FAIL monitor cfg%0d got=%h exp=%h", c, o[c], expv(c)); end end
  endtask
  task automatic test_random();
    logic [3:0] w_a;
    for (int n = 0; n < 400; n++) begin
      w_a = 4'($urandom_range(0, 15));
      drive($urandom_range(0, 3) == 0 ? w_a : 4'($urandom_range(0, 15)),
            $urandom_range(0, 3) == 0 ? w_a : 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), w_a, 8'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0 ? w_a : 4'($urandom_range(0, 15)));
      for (int c = 0; c < 3; c++) begin n_cmp++; if (o[c] !== expv(c)) begin n_fail++; $display("FAIL random%0d cfg%0d got=%h exp=%h", n, c, o[c], expv(c)); end end
      clk_edge();
    end
  endtask
  task automatic test_async_reset();
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 4'd1); clk_edge();
    drive(0, 0, 0, 0, 0, 1, 4'd6); clk_edge();
    drive(0, 0, 0, 0, 0, 1, 4'd7); clk_edge();
    drive(4'd6, 4'd7, 0, 0, 0, 0, 0);
    n_cmp++; if ({o[1].oc, o[1].p1, o[1].p2} !== {5'd3, 1'b0, 1'b0}) begin n_fail++; $display("FAIL three_pend got=%0d/%b%b exp=3/00", o[1].oc, o[1].p1, o[1].p2); end
    #1 Reset = 1'b0;
    model_clear();
    #1;
    for (int c = 0; c < 3; c++) begin n_cmp++; if (o[c] !== expv(c)) begin n_fail++; $display("FAIL async_rst cfg%0d got=%h exp=%h", c, o[c], expv(c)); end end
    n_cmp++; if ({o[1].oc, o[1].p1, o[1].p2} !== {5'd0, 1'b1, 1'b1}) begin n_fail++; $display("FAIL async_rst_now got=%0d/%b%b exp=0/11", o[1].oc, o[1].p1, o[1].p2); end
    @(negedge Clock);
    Reset = 1'b1;
  endtask
  initial begin
    test_reset();
    @(negedge Clock);
    test_bypass();
    test_reserve();
    test_same_cycle();
    test_zero_r0();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
